// File: rtl/rr_mux_arbiter_4.sv
// Round-robin 4:1 mux arbiter with bounded burst ownership and a single-entry
// registered output stage under valid/ready backpressure.
module rr_mux_arbiter_4 #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req_valid,
  input  logic [4*WIDTH-1:0] req_data,
  output logic [3:0]         req_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_src,
  input  logic               out_ready
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_src_q, out_src_d;

  logic             can_accept;
  logic             cand_found;
  logic [1:0]       cand_idx;
  logic [1:0]       idx;
  logic [1:0]       sel;
  logic             grant;
  logic [WIDTH-1:0] sel_data;

  // Round-robin search: scanning offsets downward leaves the nearest hit to ptr.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = 2'd0;
    idx        = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (req_valid[idx]) begin
        cand_found = 1'b1;
        cand_idx   = idx;
      end
    end
  end

  always_comb begin
    can_accept = !out_valid_q || out_ready;
    sel        = (state_q == LOCKED) ? owner_q : cand_idx;
    grant      = 1'b0;
    if (rst && can_accept) begin
      if (state_q == LOCKED) grant = req_valid[owner_q];
      else                   grant = cand_found;
    end
    req_ready = grant ? (4'b0001 << sel) : 4'b0000;
    sel_data  = '0;
    for (int i = 0; i < 4; i++) begin
      if (sel == 2'(i)) sel_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;

    case (state_q)
      IDLE: begin
        if (grant) begin
          if (MAX_BURST == 1) begin
            ptr_d = sel + 2'd1;
          end else begin
            state_d = LOCKED;
            owner_d = sel;
            cnt_d   = 4'd1;
          end
        end
      end
      LOCKED: begin
        // An owner that goes quiet forfeits the rest of its burst.
        if (!req_valid[owner_q]) begin
          state_d = IDLE;
          ptr_d   = owner_q + 2'd1;
          cnt_d   = 4'd0;
        end else if (grant) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == 4'(MAX_BURST)) begin
            state_d = IDLE;
            ptr_d   = owner_q + 2'd1;
            cnt_d   = 4'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_src_d   = sel;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      owner_q     <= 2'd0;
      cnt_q       <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Directed bench for rr_mux_arbiter_4: one instance with MAX_BURST=4 and one
// with MAX_BURST=1 share the same stimulus.
module tb_rr_mux_arbiter_4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic        out_ready;

  logic [3:0]  req_ready4, req_ready1;
  logic        out_valid4, out_valid1;
  logic [3:0]  out_data4, out_data1;
  logic [1:0]  out_src4, out_src1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter_4 #(.WIDTH(4), .MAX_BURST(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready4), .out_valid(out_valid4), .out_data(out_data4),
    .out_src(out_src4), .out_ready(out_ready)
  );

  rr_mux_arbiter_4 #(.WIDTH(4), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready1), .out_valid(out_valid1), .out_data(out_data1),
    .out_src(out_src1), .out_ready(out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = 4'b0000;
    req_data = 16'h0000;
    out_ready = 1'b1;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 4'b1111;
    req_data = 16'hFFFF;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if ({req_ready4, req_ready1} !== 8'h00) begin
        miscompares++;
        $display("[TB] FAIL reset_ready cyc%0d: got %b/%b expected 0000/0000", c, req_ready4, req_ready1);
      end
      tick();
    end
    rst = 1'b1;
    req_valid = 4'b0000;
    #1;
    vectors++;
    if ({out_valid4, out_data4, out_src4} !== 7'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_out4: got v=%b d=%h s=%0d expected 0/0/0", out_valid4, out_data4, out_src4);
    end
    vectors++;
    if ({out_valid1, out_data1, out_src1} !== 7'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_out1: got v=%b d=%h s=%0d expected 0/0/0", out_valid1, out_data1, out_src1);
    end
  endtask

  task automatic test_single();
    logic [3:0] words [3] = '{4'h5, 4'h6, 4'h7};
    do_reset();
    req_valid = 4'b0100;
    for (int b = 0; b < 3; b++) begin
      req_data[8 +: 4] = words[b];
      #1;
      vectors++;
      if (req_ready4 !== 4'b0100) begin
        miscompares++;
        $display("[TB] FAIL single_ready b%0d: got %b expected 0100", b, req_ready4);
      end
      tick();
      vectors++;
      if ({out_valid4, out_src4, out_data4} !== {1'b1, 2'd2, words[b]}) begin
        miscompares++;
        $display("[TB] FAIL single_out b%0d: got v=%b s=%0d d=%h expected v=1 s=2 d=%h",
                 b, out_valid4, out_src4, out_data4, words[b]);
      end
    end
    req_valid = 4'b0000;
    tick();
    vectors++;
    if (out_valid4 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_drain: got out_valid=%b expected 0", out_valid4);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_src [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    req_data = 16'hBA98;
    req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      #1;
      vectors++;
      if (req_ready1 !== (4'b0001 << exp_src[c])) begin
        miscompares++;
        $display("[TB] FAIL fair_ready c%0d: got %b expected index %0d", c, req_ready1, exp_src[c]);
      end
      tick();
      vectors++;
      if ({out_valid1, out_src1, out_data1} !== {1'b1, exp_src[c], 4'h8 + 4'(exp_src[c])}) begin
        miscompares++;
        $display("[TB] FAIL fair_out c%0d: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                 c, out_valid1, out_src1, out_data1, exp_src[c], 4'h8 + 4'(exp_src[c]));
      end
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_burst();
    logic [1:0] exp_src [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                                 2'd0, 2'd0, 2'd0, 2'd0};
    do_reset();
    req_data = 16'h00BA;
    req_valid = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      tick();
      vectors++;
      if ({out_valid4, out_src4, out_data4} !== {1'b1, exp_src[c], (exp_src[c] == 2'd0) ? 4'hA : 4'hB}) begin
        miscompares++;
        $display("[TB] FAIL burst_out c%0d: got v=%b s=%0d d=%h expected v=1 s=%0d",
                 c, out_valid4, out_src4, out_data4, exp_src[c]);
      end
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0001;
    req_data[3:0] = 4'h1;
    tick();
    out_ready = 1'b0;
    req_data[3:0] = 4'h2;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (req_ready4 !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL bp_ready c%0d: got %b expected 0000", c, req_ready4);
      end
      tick();
      vectors++;
      if ({out_valid4, out_src4, out_data4} !== {1'b1, 2'd0, 4'h1}) begin
        miscompares++;
        $display("[TB] FAIL bp_hold c%0d: got v=%b s=%0d d=%h expected v=1 s=0 d=1",
                 c, out_valid4, out_src4, out_data4);
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready4 !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL bp_release_ready: got %b expected 0001", req_ready4);
    end
    tick();
    vectors++;
    if ({out_valid4, out_src4, out_data4} !== {1'b1, 2'd0, 4'h2}) begin
      miscompares++;
      $display("[TB] FAIL bp_refill: got v=%b s=%0d d=%h expected v=1 s=0 d=2",
               out_valid4, out_src4, out_data4);
    end
    req_valid = 4'b0000;
    tick();
    vectors++;
    if (out_valid4 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_no_dup: got out_valid=%b expected 0", out_valid4);
    end
  endtask

  task automatic test_owner_drop_and_reset();
    do_reset();
    req_data = 16'h3CC4;
    req_valid = 4'b1000;
    tick();
    tick();
    vectors++;
    if ({out_valid4, out_src4, out_data4} !== {1'b1, 2'd3, 4'h3}) begin
      miscompares++;
      $display("[TB] FAIL drop_beat2: got v=%b s=%0d d=%h expected v=1 s=3 d=3",
               out_valid4, out_src4, out_data4);
    end
    req_valid = 4'b0001;
    #1;
    vectors++;
    if (req_ready4 !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL drop_bubble_ready: got %b expected 0000", req_ready4);
    end
    tick();
    vectors++;
    if (out_valid4 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL drop_bubble_out: got out_valid=%b expected 0", out_valid4);
    end
    #1;
    vectors++;
    if (req_ready4 !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL drop_next_ready: got %b expected 0001", req_ready4);
    end
    tick();
    vectors++;
    if ({out_valid4, out_src4, out_data4} !== {1'b1, 2'd0, 4'h4}) begin
      miscompares++;
      $display("[TB] FAIL drop_next_out: got v=%b s=%0d d=%h expected v=1 s=0 d=4",
               out_valid4, out_src4, out_data4);
    end
    req_valid = 4'b1110;
    rst = 1'b0;
    #1;
    vectors++;
    if (req_ready4 !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL midreset_ready: got %b expected 0000", req_ready4);
    end
    tick();
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid4 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_out: got out_valid=%b expected 0", out_valid4);
    end
    vectors++;
    if (req_ready4 !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL midreset_grant_ready: got %b expected 0010", req_ready4);
    end
    tick();
    vectors++;
    if ({out_valid4, out_src4, out_data4} !== {1'b1, 2'd1, 4'hC}) begin
      miscompares++;
      $display("[TB] FAIL midreset_grant_out: got v=%b s=%0d d=%h expected v=1 s=1 d=c",
               out_valid4, out_src4, out_data4);
    end
    req_valid = 4'b0000;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 4'b0000;
    req_data = 16'h0000;
    out_ready = 1'b1;
    test_reset();
    test_single();
    test_fairness();
    test_burst();
    test_backpressure();
    test_owner_drop_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
